// File: rtl/sc_readback_checker_if.sv
// Bus between slow-control firmware and the MAROC readback checker.
// err_map is present only when SC_RB_ERRMAP_EN is defined.
`timescale 1ns/1ps
interface sc_readback_checker_if #(
  parameter int FRAME_LEN = 829,
  parameter int CNT_W     = 10
);
  logic                 start;
  logic                 abort;
  logic [FRAME_LEN-1:0] expected;
  logic                 q_valid;
  logic                 Q_SC;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CNT_W-1:0]     err_count;
  logic [CNT_W-1:0]     first_err_idx;
  logic                 first_err_valid;
`ifdef SC_RB_ERRMAP_EN
  logic [FRAME_LEN-1:0] err_map;

  modport master (
    output start, abort, expected, q_valid, Q_SC,
    input  busy, done, pass, err_count, first_err_idx, first_err_valid, err_map
  );
  modport slave (
    input  start, abort, expected, q_valid, Q_SC,
    output busy, done, pass, err_count, first_err_idx, first_err_valid, err_map
  );
`else
  modport master (
    output start, abort, expected, q_valid, Q_SC,
    input  busy, done, pass, err_count, first_err_idx, first_err_valid
  );
  modport slave (
    input  start, abort, expected, q_valid, Q_SC,
    output busy, done, pass, err_count, first_err_idx, first_err_valid
  );
`endif
endinterface

// File: rtl/sc_readback_checker.sv
// Checks the MAROC slow-control serial readback (Q_SC) against a latched expected frame, LSB first.
// Define SC_RB_ERRMAP_EN to add a per-bit mismatch map output.
`timescale 1ns/1ps
module sc_readback_checker #(
  parameter int FRAME_LEN = 829,
  parameter int CNT_W     = 10
) (
  input logic                  CK_in,
  input logic                  RSTn,
  sc_readback_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]     err_count_q, err_count_d;
  logic [CNT_W-1:0]     first_err_idx_q, first_err_idx_d;
  logic                 first_err_valid_q, first_err_valid_d;
  logic                 pass_q, pass_d;
  logic                 busy_s, done_s;
  logic                 mismatch_s, last_bit_s;
`ifdef SC_RB_ERRMAP_EN
  logic [FRAME_LEN-1:0] err_map_q, err_map_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  assign mismatch_s = bus.Q_SC ^ shadow_q[0];
  assign last_bit_s = (bit_idx_q == CNT_W'(FRAME_LEN - 1));

  // FSM state register
  always_ff @(posedge CK_in or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) state_d = ST_CAPTURE;
          else           state_d = ST_IDLE;
        end
        ST_CAPTURE: begin
          if (bus.q_valid && last_bit_s) state_d = ST_DONE;
          else                           state_d = ST_CAPTURE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs decoded straight from the state flops
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_q)
      ST_CAPTURE: busy_s = 1'b1;
      ST_DONE:    done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath next-state: arm on start, compare and shift on each valid bit
  always_comb begin
    shadow_d          = shadow_q;
    bit_idx_d         = bit_idx_q;
    err_count_d       = err_count_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_valid_d = first_err_valid_q;
    pass_d            = pass_q;
`ifdef SC_RB_ERRMAP_EN
    err_map_d         = err_map_q;
`endif
    if (bus.abort) begin
      pass_d = 1'b0;
    end else if ((state_q == ST_IDLE) && bus.start) begin
      shadow_d          = bus.expected;
      bit_idx_d         = '0;
      err_count_d       = '0;
      first_err_idx_d   = '0;
      first_err_valid_d = 1'b0;
      pass_d            = 1'b0;
`ifdef SC_RB_ERRMAP_EN
      err_map_d         = '0;
`endif
    end else if ((state_q == ST_CAPTURE) && bus.q_valid) begin
      shadow_d  = {1'b0, shadow_q[FRAME_LEN-1:1]};
      bit_idx_d = bit_idx_q + CNT_W'(1);
      if (mismatch_s) begin
        err_count_d = sat_inc(err_count_q);
        if (!first_err_valid_q) begin
          first_err_idx_d   = bit_idx_q;
          first_err_valid_d = 1'b1;
        end else begin
          first_err_idx_d   = first_err_idx_q;
          first_err_valid_d = first_err_valid_q;
        end
`ifdef SC_RB_ERRMAP_EN
        err_map_d[bit_idx_q] = 1'b1;
`endif
      end else begin
        err_count_d = err_count_q;
      end
      // Verdict is ready in the same cycle done is high
      if (last_bit_s) pass_d = (err_count_d == '0);
      else            pass_d = pass_q;
    end else begin
      pass_d = pass_q;
    end
  end

  // Datapath registers
  always_ff @(posedge CK_in or negedge RSTn) begin
    if (!RSTn) begin
      shadow_q          <= '0;
      bit_idx_q         <= '0;
      err_count_q       <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
      pass_q            <= 1'b0;
`ifdef SC_RB_ERRMAP_EN
      err_map_q         <= '0;
`endif
    end else begin
      shadow_q          <= shadow_d;
      bit_idx_q         <= bit_idx_d;
      err_count_q       <= err_count_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_valid_q <= first_err_valid_d;
      pass_q            <= pass_d;
`ifdef SC_RB_ERRMAP_EN
      err_map_q         <= err_map_d;
`endif
    end
  end

  assign bus.busy            = busy_s;
  assign bus.done            = done_s;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err_idx   = first_err_idx_q;
  assign bus.first_err_valid = first_err_valid_q;
`ifdef SC_RB_ERRMAP_EN
  assign bus.err_map         = err_map_q;
`endif

endmodule

// File: tb/tb_sc_readback_checker.sv
// Directed self-checking bench for sc_readback_checker.
`timescale 1ns/1ps
module tb_sc_readback_checker;
  localparam int FL = 829;
  localparam int CW = 10;

  logic CK_in = 1'b0;
  logic RSTn;
  always #5 CK_in = ~CK_in;

  sc_readback_checker_if #(.FRAME_LEN(FL), .CNT_W(CW)) bus ();
  sc_readback_checker #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .CK_in(CK_in),
    .RSTn (RSTn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt = 0;
  logic [FL-1:0] pat;

  always @(posedge CK_in) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge CK_in);
    #1;
  endtask

  task automatic do_start(input logic [FL-1:0] frame);
    bus.expected = frame;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic send_bits(input logic [FL-1:0] data, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      bus.q_valid = 1'b1;
      bus.Q_SC    = data[i];
      tick();
    end
    bus.q_valid = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.q_valid = 1'b0; bus.Q_SC = 1'b0; bus.expected = '0;
    tick(); tick();
    n_checks++;
    if ({bus.busy, bus.done, bus.pass, bus.first_err_valid} !== 4'b0000) begin
      n_fails++; $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.pass, bus.first_err_valid});
    end
    n_checks++;
    if ({bus.err_count, bus.first_err_idx} !== 20'd0) begin
      n_fails++; $display("FAIL reset_counts: got err=%0d idx=%0d want 0/0", bus.err_count, bus.first_err_idx);
    end
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_match();
    int d0;
    d0 = done_cnt;
    do_start(pat);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fails++; $display("FAIL match_busy: got %b want 1", bus.busy); end
    send_bits(pat, 0, FL);
    n_checks++;
    if (bus.done !== 1'b1) begin n_fails++; $display("FAIL match_done: got %b want 1", bus.done); end
    n_checks++;
    if (bus.pass !== 1'b1) begin n_fails++; $display("FAIL match_pass: got %b want 1", bus.pass); end
    n_checks++;
    if (bus.err_count !== 10'd0 || bus.first_err_valid !== 1'b0) begin
      n_fails++; $display("FAIL match_err: got err=%0d fev=%b want 0/0", bus.err_count, bus.first_err_valid);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pass !== 1'b1) begin
      n_fails++; $display("FAIL match_after: got done=%b busy=%b pass=%b want 0/0/1", bus.done, bus.busy, bus.pass);
    end
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fails++; $display("FAIL match_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_mismatch();
    logic [FL-1:0] stream;
    logic [FL-1:0] map_exp;
    stream = pat;
    stream[3] = ~stream[3];
    stream[700] = ~stream[700];
    map_exp = '0;
    map_exp[3] = 1'b1;
    map_exp[700] = 1'b1;
    do_start(pat);
    send_bits(stream, 0, FL);
    n_checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b0) begin
      n_fails++; $display("FAIL mism_verdict: got done=%b pass=%b want 1/0", bus.done, bus.pass);
    end
    n_checks++;
    if (bus.err_count !== 10'd2) begin n_fails++; $display("FAIL mism_count: got %0d want 2", bus.err_count); end
    n_checks++;
    if (bus.first_err_idx !== 10'd3 || bus.first_err_valid !== 1'b1) begin
      n_fails++; $display("FAIL mism_first: got idx=%0d fev=%b want 3/1", bus.first_err_idx, bus.first_err_valid);
    end
`ifdef SC_RB_ERRMAP_EN
    n_checks++;
    if (bus.err_map !== map_exp) begin n_fails++; $display("FAIL mism_map: err_map differs from bits {3,700}"); end
`endif
    tick();
  endtask

  task automatic test_gapped();
    int cyc;
    int b;
    cyc = 0;
    b = 0;
    do_start(pat);
    while (bus.done !== 1'b1 && cyc < 3000) begin
      if ((cyc % 2) == 0 && b < FL) begin
        bus.q_valid = 1'b1; bus.Q_SC = pat[b]; b++;
      end else begin
        bus.q_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.q_valid = 1'b0;
    n_checks++;
    if (cyc !== 1657) begin n_fails++; $display("FAIL gap_latency: got %0d cycles want 1657", cyc); end
    n_checks++;
    if (bus.pass !== 1'b1 || bus.err_count !== 10'd0) begin
      n_fails++; $display("FAIL gap_pass: got pass=%b err=%0d want 1/0", bus.pass, bus.err_count);
    end
    tick();
  endtask

  task automatic test_start_busy();
    do_start(pat);
    send_bits(pat, 0, 400);
    bus.start = 1'b1; bus.expected = '0;
    bus.q_valid = 1'b1; bus.Q_SC = pat[400];
    tick();
    bus.start = 1'b0; bus.q_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.err_count !== 10'd0) begin
      n_fails++; $display("FAIL sbusy_mid: got busy=%b err=%0d want 1/0", bus.busy, bus.err_count);
    end
    send_bits(pat, 401, FL);
    n_checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.err_count !== 10'd0) begin
      n_fails++; $display("FAIL sbusy_end: got done=%b pass=%b err=%0d want 1/1/0", bus.done, bus.pass, bus.err_count);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [FL-1:0] stream;
    int d0;
    stream = pat;
    stream[50] = ~stream[50];
    do_start(pat);
    send_bits(stream, 0, 100);
    d0 = done_cnt;
    bus.abort = 1'b1; bus.q_valid = 1'b1; bus.Q_SC = stream[100];
    tick();
    bus.abort = 1'b0; bus.q_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0) begin
      n_fails++; $display("FAIL abort_flags: got busy=%b done=%b pass=%b want 0/0/0", bus.busy, bus.done, bus.pass);
    end
    n_checks++;
    if (bus.err_count !== 10'd1 || bus.first_err_idx !== 10'd50 || bus.first_err_valid !== 1'b1) begin
      n_fails++; $display("FAIL abort_partial: got err=%0d idx=%0d fev=%b want 1/50/1", bus.err_count, bus.first_err_idx, bus.first_err_valid);
    end
    for (int k = 0; k < 4; k++) tick();
    n_checks++;
    if (done_cnt !== d0) begin n_fails++; $display("FAIL abort_nodone: got %0d pulses want 0", done_cnt - d0); end
    do_start(pat);
    send_bits(pat, 0, FL);
    n_checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.err_count !== 10'd0 || bus.first_err_valid !== 1'b0) begin
      n_fails++; $display("FAIL abort_restart: got done=%b pass=%b err=%0d fev=%b want 1/1/0/0", bus.done, bus.pass, bus.err_count, bus.first_err_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [FL-1:0] ones;
    int d0;
    ones = '1;
    do_start('0);
    send_bits(ones, 0, 500);
    n_checks++;
    if (bus.err_count !== 10'd500) begin n_fails++; $display("FAIL rst_partial: got %0d want 500", bus.err_count); end
    d0 = done_cnt;
    RSTn = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.pass, bus.first_err_valid} !== 4'b0000 || {bus.err_count, bus.first_err_idx} !== 20'd0) begin
      n_fails++; $display("FAIL rst_async: got busy=%b err=%0d fev=%b want all zero", bus.busy, bus.err_count, bus.first_err_valid);
    end
`ifdef SC_RB_ERRMAP_EN
    n_checks++;
    if (bus.err_map !== '0) begin n_fails++; $display("FAIL rst_map: err_map not cleared"); end
`endif
    tick(); tick();
    RSTn = 1'b1;
    bus.q_valid = 1'b1; bus.Q_SC = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    bus.q_valid = 1'b0;
    n_checks++;
    if (done_cnt !== d0 || bus.busy !== 1'b0) begin
      n_fails++; $display("FAIL rst_nodone: got pulses=%0d busy=%b want 0/0", done_cnt - d0, bus.busy);
    end
    do_start('0);
    send_bits(ones, 0, FL);
    n_checks++;
    if (bus.done !== 1'b1 || bus.err_count !== 10'd829 || bus.pass !== 1'b0) begin
      n_fails++; $display("FAIL rst_allones: got done=%b err=%0d pass=%b want 1/829/0", bus.done, bus.err_count, bus.pass);
    end
    n_checks++;
    if (bus.first_err_idx !== 10'd0 || bus.first_err_valid !== 1'b1) begin
      n_fails++; $display("FAIL rst_first: got idx=%0d fev=%b want 0/1", bus.first_err_idx, bus.first_err_valid);
    end
    tick();
  endtask

  initial begin
    pat = {{(FL-1){1'b0}}, 1'b1};
    for (int i = 0; i < 207; i++) begin
      pat = (pat << 4) | ((i % 2 == 0) ? FL'(5) : FL'(10));
    end
    test_reset();
    test_match();
    test_mismatch();
    test_gapped();
    test_start_busy();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
